// File: rtl/iot_pkg.sv
// Shared constants and types for the IoT event encoder.
package iot_pkg;

  localparam int unsigned NUM_DEV  = 8;
  localparam int unsigned DEV_ID_W = 3;

  typedef enum logic {
    EVT_OFF = 1'b0,
    EVT_ON  = 1'b1
  } evt_pol_e;

endpackage

// File: rtl/iot_evt_arbiter.sv
// Selects one pending device. Define IOT_EVT_RR_EN for round-robin starting after
// the last grant; otherwise the lowest pending index wins.
module iot_evt_arbiter
  import iot_pkg::*;
(
  input  logic [NUM_DEV-1:0]  req,
  input  logic [DEV_ID_W-1:0] last,
  output logic [NUM_DEV-1:0]  gnt,
  output logic [DEV_ID_W-1:0] idx,
  output logic                valid
);

`ifdef IOT_EVT_RR_EN
  logic [DEV_ID_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_DEV; k++) begin
      cand = DEV_ID_W'((32'(last) + k) % NUM_DEV);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
`else
  logic                unused_last;
  logic [DEV_ID_W-1:0] cand;

  assign unused_last = ^last;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_DEV; k++) begin
      cand = DEV_ID_W'(k);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
`endif

endmodule

// File: rtl/iot_event_encoder.sv
// Turns per-device level changes into one-per-cycle on/off event strobes.
// Arbitration mode selected by IOT_EVT_RR_EN (see iot_evt_arbiter).
module iot_event_encoder
  import iot_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic [NUM_DEV-1:0]  dev_status,
  output logic                change,
  output logic                on_off,
  output logic [DEV_ID_W-1:0] dev_id,
  output logic                busy
);

  logic [NUM_DEV-1:0]  prev_q, pend_on, pend_off;
  logic [NUM_DEV-1:0]  req, gnt, edges, on_edge, off_edge;
  logic [NUM_DEV-1:0]  kept_on, kept_off, nxt_on, nxt_off;
  logic [DEV_ID_W-1:0] gnt_idx, last_q;
  logic                gnt_valid, emit, emit_on;

  iot_evt_arbiter u_arb (
    .req   (req),
    .last  (last_q),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .valid (gnt_valid)
  );

  assign busy = |req;

  always_comb begin
    req      = pend_on | pend_off;
    edges    = dev_status ^ prev_q;
    on_edge  = edges & dev_status;
    off_edge = edges & ~dev_status;
    emit     = !hold && gnt_valid;
    emit_on  = |(gnt & pend_on);
    kept_on  = pend_on;
    kept_off = pend_off;
    if (emit) begin
      if (emit_on) kept_on  = pend_on & ~gnt;
      else         kept_off = pend_off & ~gnt;
    end
    // Grant clear applies first; an opposite-polarity edge then cancels the
    // surviving pending bit instead of queueing a second event.
    nxt_on  = (kept_on & ~off_edge) | (on_edge & ~kept_off);
    nxt_off = (kept_off & ~on_edge) | (off_edge & ~kept_on);
  end

  // last_q resets to the top index so the first round-robin search begins at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      pend_on  <= '0;
      pend_off <= '0;
      change   <= 1'b0;
      on_off   <= EVT_OFF;
      dev_id   <= '0;
      last_q   <= '1;
    end else begin
      prev_q   <= dev_status;
      pend_on  <= nxt_on;
      pend_off <= nxt_off;
      change   <= emit;
      if (emit) begin
        on_off <= emit_on ? EVT_ON : EVT_OFF;
        dev_id <= gnt_idx;
        last_q <= gnt_idx;
      end
    end
  end

endmodule
